bus_ram_responder: RTL and testbench
====================================

Name: bus_ram_responder

Overview:
- Memory-side responder for the core's valid/ready load/store bus. Receives the byte-aligned address, write strobes and replicated write data the core produces, and returns a full 32-bit word on rdata; the core extracts and sign-extends bytes and half-words.
- Implements word-organised RAM with byte-lane writes, a programmable number of wait states and address-range decoding.
- Sits on the data bus (or the instruction bus, read-only use) between the core and the system.

Parameters:
- ADDRESS, 32'h0000_0000, byte base address of the RAM window; must be aligned to 4*SIZE.
- SIZE, 1024, capacity in 32-bit words; power of two, minimum 2.
- WAIT_STATES, 0, extra cycles inserted between request acceptance and the ready pulse; range 0 to 15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- valid  input  1  request present; the initiator holds it until it sees ready.
- ready  output  1  one-cycle completion pulse.
- address  input  32  byte address; bits [1:0] are ignored.
- wstrobe  input  4  byte-lane write enables; 4'b0000 means read.
- wdata  input  32  write data, already lane-replicated by the initiator.
- rdata  output  32  read data; valid while ready=1.

Behaviour:
- Reset: asserting reset_n=0 takes effect immediately, regardless of the clock.
  - State returns to IDLE; ready=0; rdata=0; the wait counter and request capture registers are cleared.
  - RAM contents are not reset and are preserved across reset.
- FSM states are IDLE, WAIT and RESPOND.
- IDLE: if valid=1, capture address word index, in_range, wstrobe and wdata.
  - Go to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0; otherwise go directly to RESPOND.
- WAIT: decrement the counter; when it is 0, go to RESPOND.
- RESPOND: ready=1 for exactly one cycle, then IDLE.
- Latency: ready goes high WAIT_STATES+1 cycles after the edge that sampled valid. The minimum is 1 cycle, because the RAM read is synchronous.
- Read data:
  - rdata is registered, loaded from mem[index] on the edge entering RESPOND.
  - It holds its value after ready falls until the next RESPOND.
  - For writes, rdata returns the pre-write word (read-before-write).
- Writes: on the edge leaving RESPOND, each lane i with captured wstrobe[i]=1 gets mem[index][8i+7:8i] = wdata[8i+7:8i]. Lanes with wstrobe[i]=0 are untouched.
- Address decode:
  - in_range = (address - ADDRESS) < 4*SIZE, evaluated unsigned over 32 bits.
  - index = (address - ADDRESS)[log2(SIZE)+1:2].
  - Out of range: the handshake completes normally, rdata=0 and no RAM write occurs. There is no error signal.
- Back-to-back: valid is ignored during WAIT and RESPOND. A request still held after ready is re-sampled in IDLE the following cycle, so the peak throughput is one request per WAIT_STATES+2 cycles.
  - The initiator must drop valid or present a new request in the cycle after ready. Otherwise the held request is serviced again.
- Request changes mid-transaction: fields are captured at acceptance. Changes to address, wstrobe or wdata, or dropping valid during WAIT/RESPOND, do not affect the transaction in flight; ready still pulses.
- Reset mid-transaction: the pending write is discarded (the RAM is not modified) and no ready pulse is emitted.
- wstrobe is not checked for a legal pattern; any 4-bit mask is applied as given.

Decomposition:
- Verdata_pkg, existing:
  - word_t: address, wdata, rdata.
  - wstrobe_t: wstrobe.
- Same package, additions:
  - bus_responder_state_t: enum IDLE, WAIT, RESPOND.
- Sub-module byte_lane_ram holds the storage.
  - Parameter SIZE.
  - Ports: clk, index, read enable, wstrobe_t write lanes, word_t wdata, registered word_t rdata.
  - No reset, so the tool can infer block RAM.
- The FSM, counter, decode and capture registers stay in bus_ram_responder.

Test Plan:
- Reset state: hold reset_n=0, then release, WAIT_STATES=2 -> ready=0 and rdata=0 during and after reset; no ready without valid.
- Word write then read, WAIT_STATES=0, ADDRESS=0:
  - Write to 0x10 with wstrobe=4'hF, wdata=32'hDEADBEEF -> ready high exactly 1 cycle after valid sampled.
  - Read of 0x10 with wstrobe=0 -> rdata=32'hDEADBEEF with ready.
- Byte-lane merge:
  - Preload 0x20=32'h11223344, then write 0x22 with wstrobe=4'b0100, wdata=32'hAAAAAAAA.
  - That write returns rdata=32'h11223344 with ready (read-before-write).
  - A subsequent read of 0x20 -> 32'h11AA3344.
- Wait states, WAIT_STATES=3: request held continuously ->
  - ready pulses 4 cycles after acceptance, repeating every 5 cycles;
  - address changed to 0x30 during WAIT is ignored (old index serviced).
- Out of range, ADDRESS=32'h1000, SIZE=16:
  - write 32'h1040 = 32'hFFFFFFFF -> ready pulses, nothing written;
  - read 32'h0FFC -> rdata=0;
  - read 32'h1000 unchanged.
- Reset mid-write, WAIT_STATES=2: assert reset_n=0 during WAIT of a write to 0x8 -> no ready pulse; a read of 0x8 after reset returns the old value.

Source files
------------

// File: rtl/bus_ram_responder_pkg.sv
// Shared types for the RAM responder on the core's valid/ready load/store bus.
//   word_t                 : 32-bit bus word (address, write data, read data)
//   wstrobe_t              : one write enable per byte lane, all-zero means read
//   bus_responder_state_t  : responder handshake states
package bus_ram_responder_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / 8;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LANES-1:0]  wstrobe_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } bus_responder_state_t;

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised storage built from one byte-wide memory per lane, so each
// lane write enable maps directly onto its own RAM.
// There is no reset, so the arrays can be mapped onto block RAM.
// Ports:
//   clk       : clock, reads and writes on the rising edge
//   index     : word index shared by read and write
//   rd_en     : load rdata from mem[index]
//   wr_lanes  : per-lane write enables for mem[index]
//   wdata     : lane-replicated write data
//   rdata     : registered read word, holds while rd_en is low
module byte_lane_ram
    import bus_ram_responder_pkg::*;
#(
    parameter int  SIZE  = 1024,
    localparam int IDX_W = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] index,
    input  logic             rd_en,
    input  wstrobe_t         wr_lanes,
    input  word_t            wdata,
    output word_t            rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [SIZE];
            logic [7:0] lane_q;

            always_ff @(posedge clk) begin
                if (wr_lanes[gi]) begin
                    lane_mem[index] <= wdata[8*gi +: 8];
                end
                if (rd_en) begin
                    lane_q <= lane_mem[index];
                end
            end

            assign rdata[8*gi +: 8] = lane_q;
        end
    endgenerate

endmodule

// File: rtl/bus_ram_responder.sv
// Memory-side responder for the valid/ready load/store bus: a word RAM with
// byte-lane writes, a programmable number of wait states and an address
// window decode. Returns whole 32-bit words; the initiator extracts bytes.
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   valid    : request present, held by the initiator until ready
//   ready    : one-cycle completion pulse
//   address  : byte address, bits [1:0] ignored
//   wstrobe  : byte-lane write enables, 4'b0000 = read
//   wdata    : lane-replicated write data
//   rdata    : read data (pre-write word on writes), held until next response
module bus_ram_responder
    import bus_ram_responder_pkg::*;
#(
    parameter logic [31:0] ADDRESS     = 32'h0000_0000,
    parameter int          SIZE        = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     valid,
    output logic     ready,
    input  word_t    address,
    input  wstrobe_t wstrobe,
    input  word_t    wdata,
    output word_t    rdata
);

    localparam int          IDX_W     = $clog2(SIZE);
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    bus_responder_state_t state_reg, state_next;
    logic [3:0]           count_reg, count_next;

    // Request captured at acceptance; later bus changes do not disturb it.
    logic [IDX_W-1:0] index_reg;
    logic             in_range_reg;
    wstrobe_t         wstrobe_reg;
    word_t            wdata_reg;

    // Whether the word currently presented on rdata came from the RAM.
    logic             resp_in_range_reg;
    logic             resp_in_range_next;

    // Live address decode.
    word_t            offset;
    logic             in_range;
    logic [IDX_W-1:0] index;
    logic             unused_offset_bits;

    // RAM control
    logic [IDX_W-1:0] ram_index;
    logic             ram_rd_en;
    wstrobe_t         ram_wr_lanes;
    word_t            ram_rdata;

    logic             accept;
    logic             entering_respond;

    // Unsigned wrap-around subtraction makes addresses below the base look
    // huge, so a single high-bits-zero test covers both window edges.
    assign offset             = address - ADDRESS;
    assign in_range           = (offset >> (IDX_W + 2)) == '0;
    assign index              = offset[IDX_W+1:2];
    assign unused_offset_bits = ^offset[1:0];

    assign accept = (state_reg == IDLE) && valid;

    always_comb begin
        state_next         = state_reg;
        count_next         = count_reg;
        ready              = 1'b0;
        entering_respond   = 1'b0;
        resp_in_range_next = resp_in_range_reg;
        ram_index          = index_reg;
        ram_rd_en          = 1'b0;
        ram_wr_lanes       = '0;

        case (state_reg)
            IDLE: begin
                // With no wait states the RAM read must use the live
                // address, because the capture registers load on this edge.
                ram_index = index;
                if (valid) begin
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                        count_next = WAIT_INIT;
                    end else begin
                        state_next         = RESPOND;
                        entering_respond   = 1'b1;
                        resp_in_range_next = in_range;
                        ram_rd_en          = in_range;
                    end
                end
            end
            WAIT: begin
                if (count_reg == 4'd0) begin
                    state_next         = RESPOND;
                    entering_respond   = 1'b1;
                    resp_in_range_next = in_range_reg;
                    ram_rd_en          = in_range_reg;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            RESPOND: begin
                ready      = 1'b1;
                state_next = IDLE;
                // Write lands on the edge leaving RESPOND, after the read,
                // which gives read-before-write data on rdata.
                if (in_range_reg) begin
                    ram_wr_lanes = wstrobe_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            count_reg         <= 4'd0;
            index_reg         <= '0;
            in_range_reg      <= 1'b0;
            wstrobe_reg       <= '0;
            wdata_reg         <= '0;
            resp_in_range_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (accept) begin
                index_reg    <= index;
                in_range_reg <= in_range;
                wstrobe_reg  <= wstrobe;
                wdata_reg    <= wdata;
            end
            if (entering_respond) begin
                resp_in_range_reg <= resp_in_range_next;
            end
        end
    end

    byte_lane_ram #(
        .SIZE (SIZE)
    ) u_ram (
        .clk      (clk),
        .index    (ram_index),
        .rd_en    (ram_rd_en),
        .wr_lanes (ram_wr_lanes),
        .wdata    (wdata_reg),
        .rdata    (ram_rdata)
    );

    // Out-of-range responses and the post-reset state present zero; the RAM
    // output register itself has no reset.
    assign rdata = resp_in_range_reg ? ram_rdata : '0;

endmodule

// File: tb/tb_bus_ram_responder.sv
module tb_bus_ram_responder;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        valid   [N];
    logic [31:0] address [N];
    logic [3:0]  wstrobe [N];
    logic [31:0] wdata   [N];
    logic        ready   [N];
    logic [31:0] rdata   [N];

    // Instance configuration: 0 = WS2, 1 = WS0, 2 = WS3, 3 = small window at 0x1000
    int          p_ws   [N] = '{2, 0, 3, 0};
    int          p_size [N] = '{1024, 1024, 1024, 16};
    logic [31:0] p_base [N] = '{32'h0, 32'h0, 32'h0, 32'h1000};

    int total = 0;
    int bad   = 0;

    bus_ram_responder #(.ADDRESS(32'h0), .SIZE(1024), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset_n(reset_n), .valid(valid[0]), .ready(ready[0]),
        .address(address[0]), .wstrobe(wstrobe[0]), .wdata(wdata[0]), .rdata(rdata[0]));
    bus_ram_responder #(.ADDRESS(32'h0), .SIZE(1024), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset_n(reset_n), .valid(valid[1]), .ready(ready[1]),
        .address(address[1]), .wstrobe(wstrobe[1]), .wdata(wdata[1]), .rdata(rdata[1]));
    bus_ram_responder #(.ADDRESS(32'h0), .SIZE(1024), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset_n(reset_n), .valid(valid[2]), .ready(ready[2]),
        .address(address[2]), .wstrobe(wstrobe[2]), .wdata(wdata[2]), .rdata(rdata[2]));
    bus_ram_responder #(.ADDRESS(32'h1000), .SIZE(16), .WAIT_STATES(0)) u_win (
        .clk(clk), .reset_n(reset_n), .valid(valid[3]), .ready(ready[3]),
        .address(address[3]), .wstrobe(wstrobe[3]), .wdata(wdata[3]), .rdata(rdata[3]));

    // ------------------------------------------------------------------
    // Timeline model: a request accepted at edge A shows ready between
    // edges A+WS and A+WS+1, its word is written at edge A+WS+1 and the
    // next request can be accepted at edge A+WS+2.
    // ------------------------------------------------------------------
    logic [31:0] mmem [int];
    bit          m_busy       [N];
    int          m_resp       [N];
    bit          m_ready      [N];
    logic [31:0] m_rdata      [N] = '{default: 32'h0};
    bit          m_known      [N] = '{default: 1'b1};
    logic [31:0] m_resp_word  [N];
    bit          m_resp_known [N];
    bit          m_pw         [N];
    int          m_pw_key     [N];
    logic [3:0]  m_pw_strb    [N];
    logic [31:0] m_pw_data    [N];
    int          cyc = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (s[l]) r[8*l +: 8] = d[8*l +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        logic [31:0] off;
        bit          inr;
        int          key;
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i]  = 1'b0;
                m_ready[i] = 1'b0;
                m_rdata[i] = 32'h0;
                m_known[i] = 1'b1;
                m_pw[i]    = 1'b0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < N; i++) begin
                m_ready[i] = 1'b0;
                if (m_busy[i] && cyc == m_resp[i] + 1) begin
                    if (m_pw[i]) begin
                        if (mmem.exists(m_pw_key[i]))
                            mmem[m_pw_key[i]] = merge(mmem[m_pw_key[i]], m_pw_data[i], m_pw_strb[i]);
                        else if (m_pw_strb[i] == 4'hF)
                            mmem[m_pw_key[i]] = m_pw_data[i];
                        m_pw[i] = 1'b0;
                    end
                    m_busy[i] = 1'b0;
                end else if (!m_busy[i] && valid[i]) begin
                    off = address[i] - p_base[i];
                    inr = ({32'h0, off} < 64'(4 * p_size[i]));
                    key = i * 65536 + int'(off >> 2);
                    m_busy[i] = 1'b1;
                    m_resp[i] = cyc + p_ws[i];
                    if (inr) begin
                        m_resp_known[i] = mmem.exists(key);
                        m_resp_word[i]  = m_resp_known[i] ? mmem[key] : 32'h0;
                        m_pw[i]         = (wstrobe[i] != 4'h0);
                        m_pw_key[i]     = key;
                        m_pw_strb[i]    = wstrobe[i];
                        m_pw_data[i]    = wdata[i];
                    end else begin
                        m_resp_known[i] = 1'b1;
                        m_resp_word[i]  = 32'h0;
                        m_pw[i]         = 1'b0;
                    end
                end
                if (m_busy[i] && cyc == m_resp[i]) begin
                    m_ready[i] = 1'b1;
                    m_rdata[i] = m_resp_word[i];
                    m_known[i] = m_resp_known[i];
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            total++;
            if (ready[i] !== m_ready[i]) begin
                bad++;
                $display("FAIL ready inst=%0d t=%0t: got %b expected %b", i, $time, ready[i], m_ready[i]);
            end
            if (m_known[i]) begin
                total++;
                if (rdata[i] !== m_rdata[i]) begin
                    bad++;
                    $display("FAIL rdata inst=%0d t=%0t: got %h expected %h", i, $time, rdata[i], m_rdata[i]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    // Starts at #1 after a rising edge. lat counts rising edges from the
    // presentation of the request until ready is seen (WAIT_STATES+1).
    task automatic txn(input int i, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] rd, output int lat);
        valid[i] = 1'b1; address[i] = a; wstrobe[i] = s; wdata[i] = d;
        lat = -1;
        rd  = 32'h0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ready[i]) begin
                lat = k;
                rd  = rdata[i];
                break;
            end
        end
        valid[i] = 1'b0; wstrobe[i] = 4'h0;
        @(posedge clk); #1;
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL timeout inst=%0d addr=%h: no ready within 40 cycles", i, a);
        end
        $display("txn inst=%0d addr=%h strb=%h wdata=%h -> rdata=%h lat=%0d", i, a, s, d, rd, lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, r1, r2;
        int          lat, p1, p2;

        for (int i = 0; i < N; i++) begin
            valid[i] = 1'b0; address[i] = 32'h0; wstrobe[i] = 4'h0; wdata[i] = 32'h0;
        end
        reset_n = 1'b1;
        #1 reset_n = 1'b0;

        // Reset state
        repeat (3) begin
            @(posedge clk); #1;
            check32("reset_ready", {31'h0, ready[0]}, 32'h0);
            check32("reset_rdata", rdata[0], 32'h0);
        end
        reset_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check32("idle_ready", {31'h0, ready[0]}, 32'h0);
        end
        check32("idle_rdata", rdata[0], 32'h0);

        // Word write then read, no wait states
        txn(1, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat);
        check32("ws0_write_lat", lat, 32'd1);
        txn(1, 32'h10, 4'h0, 32'h0, rd, lat);
        check32("ws0_read_data", rd, 32'hDEADBEEF);
        check32("ws0_read_lat", lat, 32'd1);

        // Byte-lane merge with read-before-write
        txn(1, 32'h20, 4'hF, 32'h11223344, rd, lat);
        txn(1, 32'h22, 4'b0100, 32'hAAAAAAAA, rd, lat);
        check32("merge_prewrite", rd, 32'h11223344);
        txn(1, 32'h20, 4'h0, 32'h0, rd, lat);
        check32("merge_result", rd, 32'h11AA3344);

        // Wait states: held request, address changed during WAIT
        txn(2, 32'h40, 4'hF, 32'hCAFE0001, rd, lat);
        check32("ws3_write_lat", lat, 32'd4);
        txn(2, 32'h30, 4'hF, 32'h0BADF00D, rd, lat);
        valid[2] = 1'b1; address[2] = 32'h40; wstrobe[2] = 4'h0;
        p1 = -1; p2 = -1; r1 = 32'h0; r2 = 32'h0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (ready[2]) begin
                if (p1 < 0) begin
                    p1 = k; r1 = rdata[2];
                end else begin
                    p2 = k; r2 = rdata[2];
                    valid[2] = 1'b0;
                    break;
                end
            end
            if (k == 2) address[2] = 32'h30;
        end
        valid[2] = 1'b0;
        @(posedge clk); #1;
        $display("txn inst=2 held read: pulses at %0d,%0d data %h,%h", p1, p2, r1, r2);
        check32("ws3_first_pulse", p1, 32'd4);
        check32("ws3_second_pulse", p2, 32'd9);
        check32("ws3_old_index_data", r1, 32'hCAFE0001);
        check32("ws3_resampled_data", r2, 32'h0BADF00D);

        // Out-of-range window at 0x1000, 16 words
        txn(3, 32'h1000, 4'hF, 32'h12345678, rd, lat);
        txn(3, 32'h103C, 4'hF, 32'h5A5A5A5A, rd, lat);
        txn(3, 32'h1040, 4'hF, 32'hFFFFFFFF, rd, lat);
        check32("oor_write_lat", lat, 32'd1);
        check32("oor_write_rdata", rd, 32'h0);
        txn(3, 32'h0FFC, 4'h0, 32'h0, rd, lat);
        check32("oor_below_rdata", rd, 32'h0);
        txn(3, 32'h1000, 4'h0, 32'h0, rd, lat);
        check32("window_base_kept", rd, 32'h12345678);
        txn(3, 32'h103C, 4'h0, 32'h0, rd, lat);
        check32("window_top_word", rd, 32'h5A5A5A5A);

        // Reset in the middle of a write
        txn(0, 32'h8, 4'hF, 32'h01020304, rd, lat);
        check32("ws2_write_lat", lat, 32'd3);
        valid[0] = 1'b1; address[0] = 32'h8; wstrobe[0] = 4'hF; wdata[0] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        valid[0] = 1'b0; wstrobe[0] = 4'h0;
        repeat (3) begin
            @(posedge clk); #1;
            check32("midreset_ready", {31'h0, ready[0]}, 32'h0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        check32("after_reset_ready", {31'h0, ready[0]}, 32'h0);
        txn(0, 32'h8, 4'h0, 32'h0, rd, lat);
        check32("write_discarded", rd, 32'h01020304);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
